// File: rtl/sram_recorder.sv
// sram_recorder: record sequencer between the codec receive path and the SRAM controller.
// Latches each accepted sample, holds a write strobe for WR_CYCLES cycles with stable
// address/data, then advances the address and the recorded length.
// Optional feature macro: SRAM_RECORDER_WRAP_EN (circular recording at end of memory).
// Without it, recording stops at the last address (linear mode) and o_wrapped stays 0.
module sram_recorder #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W:0]   o_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun,
    output logic              o_wrapped
);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StWait,
        StWrite,
        StPause,
        StDone
    } state_e;

    // Index of the final strobe cycle; the counter is 4 bits since WR_CYCLES <= 15.
    localparam logic [3:0]        LastCnt = 4'(WR_CYCLES - 1);
    localparam logic [ADDR_W-1:0] AddrMax = '1;
    localparam logic [ADDR_W:0]   LenMax  = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              stop_pend_q, stop_pend_d;
    logic              pause_pend_q, pause_pend_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              overrun_q, overrun_d;
    logic              wrapped_q, wrapped_d;
    logic              busy_q, done_q;

    // Stop/pause seen either earlier in this write or on the final write cycle itself.
    logic stop_seen, pause_seen;
    state_e after_write;

    assign stop_seen  = stop_pend_q | i_stop;
    assign pause_seen = pause_pend_q | i_pause;

    // Where the sequencer goes once a write finishes below the end of memory.
    always_comb begin
        after_write = StWait;
        if (stop_seen) begin
            after_write = StDone;
        end else if (pause_seen) begin
            after_write = StPause;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stop_pend_d  = stop_pend_q;
        pause_pend_d = pause_pend_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        len_d        = len_q;
        overrun_d    = overrun_q;
        wrapped_d    = wrapped_q;

        if (!i_enable) begin
            // Abort: strobe drops at once, address and length are kept for playback.
            state_d      = StIdle;
            write_d      = 1'b0;
            cnt_d        = '0;
            stop_pend_d  = 1'b0;
            pause_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StArmed;
                    addr_d    = '0;
                    len_d     = '0;
                    overrun_d = 1'b0;
                    wrapped_d = 1'b0;
                end
                StArmed: begin
                    if (i_pause) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (i_stop) begin
                        state_d = StDone;
                    end else if (i_pause) begin
                        state_d = StPause;
                    end else if (i_valid) begin
                        data_d  = i_data;
                        write_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StWrite;
                    end
                end
                StWrite: begin
                    if (i_stop) begin
                        stop_pend_d = 1'b1;
                    end else if (i_pause) begin
                        pause_pend_d = 1'b1;
                    end else if (i_valid) begin
                        overrun_d = 1'b1;
                    end

                    if (cnt_q == LastCnt) begin
                        write_d      = 1'b0;
                        cnt_d        = '0;
                        stop_pend_d  = 1'b0;
                        pause_pend_d = 1'b0;
                        if (len_q != LenMax) begin
                            len_d = len_q + {{ADDR_W{1'b0}}, 1'b1};
                        end
                        if (addr_q != AddrMax) begin
                            addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            state_d = after_write;
                        end else begin
`ifdef SRAM_RECORDER_WRAP_EN
                            addr_d    = '0;
                            wrapped_d = 1'b1;
                            state_d   = after_write;
`else
                            state_d   = StDone;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StPause: begin
                    if (i_stop) begin
                        state_d = StDone;
                    end else if (i_pause) begin
                        state_d = StWait;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers; status flags follow the next state so they are registered.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            stop_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            len_q        <= '0;
            overrun_q    <= 1'b0;
            wrapped_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stop_pend_q  <= stop_pend_d;
            pause_pend_q <= pause_pend_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            len_q        <= len_d;
            overrun_q    <= overrun_d;
            wrapped_q    <= wrapped_d;
            busy_q       <= (state_d == StWait) || (state_d == StWrite);
            done_q       <= (state_d == StDone);
        end
    end

    assign o_write   = write_q;
    assign o_addr    = addr_q;
    assign o_data    = data_q;
    assign o_len     = len_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_overrun = overrun_q;
    assign o_wrapped = wrapped_q;

endmodule

// File: tb/tb_sram_recorder.sv
// Self-checking bench for sram_recorder (ADDR_W=3, WR_CYCLES=2): directed scenarios plus a
// randomized sample stream checked against a transaction-level reference model.
module tb_sram_recorder;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int WR = 2;
    localparam int DEPTH = 1 << AW;
`ifdef SRAM_RECORDER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          pause = 1'b0;
    logic          stop = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [AW:0]   len;
    logic          busy, done, overrun, wrapped;

    int vectors = 0;
    int miscompares = 0;

    sram_recorder #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WR)) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_enable  (enable),
        .i_pause   (pause),
        .i_stop    (stop),
        .i_valid   (valid),
        .i_data    (data),
        .o_write   (wr),
        .o_addr    (addr),
        .o_data    (wdata),
        .o_len     (len),
        .o_busy    (busy),
        .o_done    (done),
        .o_overrun (overrun),
        .o_wrapped (wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; return 1 ns after it so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_valid(input logic [DW-1:0] d);
        valid = 1'b1;
        data  = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        tick();
        pause = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        pause  = 1'b0;
        stop   = 1'b0;
        valid  = 1'b0;
        #4;
        rst_n = 1'b1;
        tick();
    endtask

    // IDLE -> ARMED -> WAIT
    task automatic arm();
        enable = 1'b1;
        tick();
        pulse_pause();
    endtask

    // Reference-model state for the randomized stream.
    int          acc;
    int          last_e;
    bit          exp_over;
    int          rises;
    int          hi_cycles;
    logic        prev_w;
    int          next_v;
    int          sent;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] ea, ed;
    logic [DW-1:0] rd;
    bit          in_write, is_done;

    initial begin
        // Reset state
        #1;
        check("rst_write", wr, 0);
        check("rst_addr", addr, 0);
        check("rst_len", len, 0);
        check("rst_flags", {busy, done, overrun, wrapped, wdata}, 0);
        do_reset();

        // Basic write
        arm();
        check("basic_busy", busy, 1);
        pulse_valid(16'hA5A5);
        check("basic_w1", {wr, addr, wdata}, {1'b1, 3'd0, 16'hA5A5});
        tick();
        check("basic_w2", {wr, addr, wdata}, {1'b1, 3'd0, 16'hA5A5});
        tick();
        check("basic_end", {wr, addr, len}, {1'b0, 3'd1, 4'd1});
        check("basic_busy2", busy, 1);

        // Overrun: second valid arrives during the write
        do_reset();
        arm();
        pulse_valid(16'h1111);
        pulse_valid(16'h2222);
        repeat (4) tick();
        check("ovr_len", len, 1);
        check("ovr_flag", overrun, 1);
        check("ovr_addr", addr, 1);
        check("ovr_data", wdata, 16'h1111);

        // Deferred pause
        do_reset();
        arm();
        pulse_valid(16'h0F0F);
        pulse_pause();
        check("dp_still_write", wr, 1);
        tick();
        check("dp_done_write", {wr, addr, len, busy}, {1'b0, 3'd1, 4'd1, 1'b0});
        pulse_valid(16'hDEAD);
        check("dp_ignored_w", wr, 0);
        tick();
        check("dp_ignored", {len, overrun}, {4'd1, 1'b0});
        pulse_pause();
        check("dp_resume", busy, 1);
        pulse_valid(16'hBEEF);
        check("dp_write2", {wr, addr, wdata}, {1'b1, 3'd1, 16'hBEEF});
        repeat (2) tick();

        // Stop, then DONE ignores pulses; re-arm clears length
        pulse_stop();
        check("stop_done", {done, busy}, {1'b1, 1'b0});
        pulse_valid(16'h5555);
        pulse_pause();
        check("stop_frozen", {wr, len, done}, {1'b0, 4'd2, 1'b1});
        enable = 1'b0;
        tick();
        check("stop_idle", {done, len, addr}, {1'b0, 4'd2, 3'd2});
        enable = 1'b1;
        tick();
        check("rearm_clear", {len, addr}, {4'd0, 3'd0});

        // Abort mid-write, then async reset mid-write
        do_reset();
        arm();
        pulse_valid(16'h0001);
        repeat (2) tick();
        pulse_valid(16'h0002);
        enable = 1'b0;
        tick();
        check("abort", {wr, busy, addr, len}, {1'b0, 1'b0, 3'd1, 4'd1});
        arm();
        check("abort_rearm", {addr, len}, {3'd0, 4'd0});
        pulse_valid(16'h0003);
        repeat (2) tick();
        pulse_valid(16'h0004);
        rst_n = 1'b0;
        #2;
        check("async_rst", {wr, addr, len, wdata, busy}, 0);
        #2;
        rst_n = 1'b1;
        enable = 1'b0;
        tick();

        // End of memory
        do_reset();
        arm();
        for (int i = 0; i < (WRAP ? DEPTH + 2 : DEPTH); i++) begin
            pulse_valid(16'(i + 16'h100));
            repeat (3) tick();
        end
        if (WRAP) begin
            check("eom_wrap", {addr, wrapped, len, done}, {3'd2, 1'b1, 4'd8, 1'b0});
        end else begin
            check("eom_lin", {addr, wrapped, len, done}, {3'd7, 1'b0, 4'd8, 1'b1});
        end
        check("eom_over", overrun, 0);

        // Randomized stream against the reference model
        do_reset();
        arm();
        acc = 0;
        last_e = -100;
        exp_over = 0;
        rises = 0;
        hi_cycles = 0;
        prev_w = 1'b0;
        sent = 0;
        next_v = 2;
        for (int e = 0; e < 120; e++) begin
            if (e == next_v && sent < 16) begin
                rd = 16'($urandom);
                valid = 1'b1;
                data = rd;
                sent++;
                next_v = e + int'($urandom_range(1, 5));
                in_write = (acc > 0) && (e <= last_e + WR);
                is_done = !WRAP && (acc == DEPTH) && (e > last_e + WR);
                if (in_write) begin
                    exp_over = 1'b1;
                end else if (!is_done) begin
                    exp_addr_q.push_back(32'(acc % DEPTH));
                    exp_data_q.push_back(32'(rd));
                    acc++;
                    last_e = e;
                end
            end
            tick();
            valid = 1'b0;
            if (wr && !prev_w) begin
                rises++;
                if (exp_addr_q.size() > 0) begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                end else begin
                    ea = 32'hFFFF_FFFF;
                    ed = 32'hFFFF_FFFF;
                end
                check("rnd_addr", 32'(addr), ea);
                check("rnd_data", 32'(wdata), ed);
            end
            if (wr) hi_cycles++;
            prev_w = wr;
        end
        check("rnd_writes", rises, acc);
        check("rnd_strobe", hi_cycles, WR * acc);
        check("rnd_len", len, (acc > DEPTH) ? DEPTH : acc);
        check("rnd_over", overrun, exp_over);
        check("rnd_addr_end", addr, WRAP ? (acc % DEPTH) : ((acc >= DEPTH) ? DEPTH - 1 : acc));
        check("rnd_done", done, !WRAP && acc >= DEPTH);
        check("rnd_wrapped", wrapped, WRAP && acc >= DEPTH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
